// File: rtl/chess_board_store_if.sv
// Purpose: bundles the game-FSM-facing write port and the board/status outputs
//   of chess_board_store into one interface.
// Signals:
//   new_game      sync pulse: reload initial position, clear stats
//   wr_en         single-cycle write strobe
//   wr_address    square index, row*8+col (row 0 = black back rank)
//   wr_piece      {colour, type}; colour 0=white, 1=black
//   board         flat board bus, square s at [4s+3:4s]
//   write_ack     one-cycle pulse in the cycle after an accepted write
//   white_captured / black_captured  saturating loss counters
//   move_count    completed moves (erase writes), wrapping
//   game_over     set once a king has been captured
//   winner        colour that captured the king; valid when game_over
//   dbg_state     game state register (0 = playing, 1 = over)
// Handshake: there is no back-pressure. A write is taken on the clock edge where
//   wr_en=1, new_game=0 and game_over=0; write_ack then pulses for exactly one
//   cycle and the new square value is on the board bus in that same cycle.
interface chess_board_store_if #(
  parameter int CNT_W  = 4,
  parameter int MOVE_W = 8
);
  logic              new_game;
  logic              wr_en;
  logic [5:0]        wr_address;
  logic [3:0]        wr_piece;
  logic [255:0]      board;
  logic              write_ack;
  logic [CNT_W-1:0]  white_captured;
  logic [CNT_W-1:0]  black_captured;
  logic [MOVE_W-1:0] move_count;
  logic              game_over;
  logic              winner;
  logic              dbg_state;

  modport master (
    output new_game, wr_en, wr_address, wr_piece,
    input  board, write_ack, white_captured, black_captured, move_count,
           game_over, winner, dbg_state
  );

  modport slave (
    input  new_game, wr_en, wr_address, wr_piece,
    output board, write_ack, white_captured, black_captured, move_count,
           game_over, winner, dbg_state
  );
endinterface

// File: rtl/chess_board_store.sv
// Purpose: registered 64-square board memory between the game FSM and the VGA
//   renderer. Takes single-square writes, drives the flat 256-bit board bus,
//   and keeps capture counts, completed-move count and the king-capture latch.
// Ports:
//   clk    system clock
//   rst    asynchronous, active-high reset (loads the initial position)
//   bus    chess_board_store_if slave modport (write port + board/status)
module chess_board_store #(
  parameter int CNT_W  = 4,
  parameter int MOVE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  chess_board_store_if.slave   bus
);

  // Square s lives at [4s+3:4s]; the most significant digit is square 63.
  localparam logic [255:0] INIT_BOARD =
    256'h43265234_11111111_00000000_00000000_00000000_00000000_99999999_CBAEDABC;

  localparam logic [2:0] T_EMPTY = 3'd0;
  localparam logic [2:0] T_KING  = 3'd6;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [255:0]      r_board;
  logic              r_ack;
  logic [CNT_W-1:0]  r_white_cap;
  logic [CNT_W-1:0]  r_black_cap;
  logic [MOVE_W-1:0] r_moves;
  logic              r_winner;

  logic              w_accept;
  logic [3:0]        w_old;
  logic              w_capture;
  logic              w_king_capture;
  logic              w_erase;

  assign w_accept       = bus.wr_en && !bus.new_game && (r_state == ST_PLAY);
  assign w_old          = r_board[{bus.wr_address, 2'b00} +: 4];
  assign w_capture      = w_accept && (w_old[2:0] != T_EMPTY) &&
                          (bus.wr_piece[2:0] != T_EMPTY) &&
                          (w_old[3] != bus.wr_piece[3]);
  assign w_king_capture = w_capture && (w_old[2:0] == T_KING);
  assign w_erase        = w_accept && (bus.wr_piece[2:0] == T_EMPTY);

  // Game state: the only state is whether a king has fallen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_PLAY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PLAY: if (bus.new_game)        w_state_nxt = ST_PLAY;
               else if (w_king_capture) w_state_nxt = ST_OVER;
      ST_OVER: if (bus.new_game)        w_state_nxt = ST_PLAY;
      default: w_state_nxt = ST_PLAY;
    endcase
  end

  // Board storage, ack and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_board     <= INIT_BOARD;
      r_ack       <= 1'b0;
      r_white_cap <= '0;
      r_black_cap <= '0;
      r_moves     <= '0;
      r_winner    <= 1'b0;
    end else if (bus.new_game) begin
      // new_game outranks any write in the same cycle: the write is dropped.
      r_board     <= INIT_BOARD;
      r_ack       <= 1'b0;
      r_white_cap <= '0;
      r_black_cap <= '0;
      r_moves     <= '0;
      r_winner    <= 1'b0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_board[{bus.wr_address, 2'b00} +: 4] <= bus.wr_piece;
      end
      // The victim colour is the colour of the piece being overwritten.
      if (w_capture) begin
        if (!w_old[3]) begin
          if (r_white_cap != {CNT_W{1'b1}}) r_white_cap <= r_white_cap + 1'b1;
        end else begin
          if (r_black_cap != {CNT_W{1'b1}}) r_black_cap <= r_black_cap + 1'b1;
        end
      end
      if (w_erase) r_moves <= r_moves + 1'b1;
      if (w_king_capture) r_winner <= bus.wr_piece[3];
    end
  end

  assign bus.board          = r_board;
  assign bus.write_ack      = r_ack;
  assign bus.white_captured = r_white_cap;
  assign bus.black_captured = r_black_cap;
  assign bus.move_count     = r_moves;
  assign bus.game_over      = (r_state == ST_OVER);
  assign bus.winner         = r_winner;
  assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_chess_board_store.sv
module tb_chess_board_store;

  localparam logic [255:0] INIT_BOARD =
    256'h43265234_11111111_00000000_00000000_00000000_00000000_99999999_CBAEDABC;
  localparam int W = 19;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [W-1:0] exp_q[$];

  chess_board_store_if #(.CNT_W(4), .MOVE_W(8)) bus_if ();

  chess_board_store #(.CNT_W(4), .MOVE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ng;
    logic       en;
    logic [5:0] addr;
    logic [3:0] piece;
    logic [3:0] exp_sq;
    logic       exp_ack;
    logic [3:0] exp_wcap;
    logic [3:0] exp_bcap;
    logic [7:0] exp_moves;
    logic       exp_go;
    logic       exp_win;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [3:0] sq_of(input logic [255:0] b, input int s);
    return b[4*s +: 4];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_board(input string name, input logic [255:0] exp);
    n_cmp++;
    if (bus_if.board !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, bus_if.board, exp);
    end
  endtask

  // Driver: called at a negedge, applies inputs across one posedge and
  // returns at the following negedge with the inputs cleared.
  task automatic pulse(input logic ng, input logic en, input logic [5:0] a,
                       input logic [3:0] p);
    bus_if.new_game   = ng;
    bus_if.wr_en      = en;
    bus_if.wr_address = a;
    bus_if.wr_piece   = p;
    @(negedge clk);
    bus_if.new_game   = 1'b0;
    bus_if.wr_en      = 1'b0;
    bus_if.wr_address = '0;
    bus_if.wr_piece   = '0;
  endtask

  task automatic chk_stats(input string name, input logic [3:0] wc, input logic [3:0] bc,
                           input logic [7:0] mv, input logic go);
    chk({name, " white_captured"}, 32'(bus_if.white_captured), 32'(wc));
    chk({name, " black_captured"}, 32'(bus_if.black_captured), 32'(bc));
    chk({name, " move_count"},     32'(bus_if.move_count),     32'(mv));
    chk({name, " game_over"},      32'(bus_if.game_over),      32'(go));
  endtask

  initial begin
    logic [W-1:0] e;
    n_cmp = 0;
    n_err = 0;
    bus_if.new_game   = 1'b0;
    bus_if.wr_en      = 1'b0;
    bus_if.wr_address = '0;
    bus_if.wr_piece   = '0;
    rst = 1'b1;

    //            ng  en  addr piece sq    ack wcap bcap moves go win
    vecs[0]  = '{1'b0, 1'b1, 6'd36, 4'h1, 4'h1, 1'b1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 6'd52, 4'h0, 4'h0, 1'b1, 4'd0, 4'd0, 8'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 6'd36, 4'h0, 4'h0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 6'd36, 4'h9, 4'h9, 1'b1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 6'd36, 4'h3, 4'h3, 1'b1, 4'd0, 4'd1, 8'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 6'd62, 4'h0, 4'h0, 1'b1, 4'd0, 4'd1, 8'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 6'd4,  4'h5, 4'h5, 1'b1, 4'd0, 4'd2, 8'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 6'd0,  4'h5, 4'hC, 1'b0, 4'd0, 4'd2, 8'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 6'd20, 4'h1, 4'h0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 6'd60, 4'hE, 4'hE, 1'b1, 4'd1, 4'd0, 8'd0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 6'd60, 4'h0, 4'h6, 1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 6'd0,  4'hB, 4'hB, 1'b1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 6'd40, 4'h8, 4'h8, 1'b1, 4'd0, 4'd0, 8'd1, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_board("reset board", INIT_BOARD);
    chk("reset sq0",  32'(sq_of(bus_if.board, 0)),  32'hC);
    chk("reset sq4",  32'(sq_of(bus_if.board, 4)),  32'hE);
    chk("reset sq60", 32'(sq_of(bus_if.board, 60)), 32'h6);
    chk("reset sq63", 32'(sq_of(bus_if.board, 63)), 32'h4);
    chk("reset ack",  32'(bus_if.write_ack), 32'd0);
    chk("reset winner", 32'(bus_if.winner), 32'd0);
    chk_stats("reset", 4'd0, 4'd0, 8'd0, 1'b0);

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back({vecs[i].exp_ack, vecs[i].exp_wcap, vecs[i].exp_bcap,
                       vecs[i].exp_moves, vecs[i].exp_go, vecs[i].exp_win});
      pulse(vecs[i].ng, vecs[i].en, vecs[i].addr, vecs[i].piece);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d sq", i), 32'(sq_of(bus_if.board, int'(vecs[i].addr))),
          32'(vecs[i].exp_sq));
      chk($sformatf("vec%0d ack", i), 32'(bus_if.write_ack), 32'(e[18]));
      chk_stats($sformatf("vec%0d", i), e[17:14], e[13:10], e[9:2], e[1]);
      chk($sformatf("vec%0d winner", i), 32'(bus_if.winner), 32'(e[0]));
      // Ack must drop back the following cycle.
      if (vecs[i].exp_ack) begin
        @(negedge clk);
        chk($sformatf("vec%0d ack drop", i), 32'(bus_if.write_ack), 32'd0);
      end
    end

    // Priority with a full-board check after a played position
    pulse(1'b0, 1'b1, 6'd36, 4'h1);
    pulse(1'b1, 1'b1, 6'd20, 4'h1);
    chk_board("priority board", INIT_BOARD);
    chk("priority ack", 32'(bus_if.write_ack), 32'd0);
    chk_stats("priority", 4'd0, 4'd0, 8'd0, 1'b0);

    // Saturation: 16 white losses on squares 16..31
    for (int i = 0; i < 16; i++) begin
      pulse(1'b0, 1'b1, 6'(16 + i), 4'h1);
      pulse(1'b0, 1'b1, 6'(16 + i), 4'h9);
      chk($sformatf("sat white_captured %0d", i), 32'(bus_if.white_captured),
          (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    chk("sat black_captured", 32'(bus_if.black_captured), 32'd0);
    chk("sat move_count", 32'(bus_if.move_count), 32'd0);

    // Wrap: 256 erase writes
    pulse(1'b1, 1'b0, 6'd0, 4'h0);
    for (int i = 0; i < 256; i++) begin
      pulse(1'b0, 1'b1, 6'd32, 4'h0);
      if (i == 254 || i == 255)
        chk($sformatf("wrap move_count %0d", i), 32'(bus_if.move_count),
            32'((i + 1) % 256));
    end
    chk("wrap ack", 32'(bus_if.write_ack), 32'd1);

    // Reset between the two writes of a move
    pulse(1'b0, 1'b1, 6'd36, 4'h1);
    chk("midmove dest", 32'(sq_of(bus_if.board, 36)), 32'h1);
    rst = 1'b1;
    #2;
    chk_board("midmove async board", INIT_BOARD);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_board("midmove board", INIT_BOARD);
    chk("midmove ack", 32'(bus_if.write_ack), 32'd0);
    chk_stats("midmove", 4'd0, 4'd0, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
